wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 17 +
 rtl/wb_stage_if.sv | 38 +++
 rtl/wb_stage_load_align.sv | 28 ++
 rtl/wb_stage.sv | 100 ++++++++++
 tb/tb_wb_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: widths, load-size encodings, reset level.
package wb_stage_pkg;

    localparam int   WB_DATA_W     = 32;
    localparam int   WB_REG_ADDR_W = 5;
    localparam int   WB_CNT_W      = 2;
    localparam logic WB_RST_ACTIVE = 1'b0;

    // 2'b11 is treated exactly like a word load
    typedef enum logic [1:0] {
        LD_BYTE   = 2'b00,
        LD_HALF   = 2'b01,
        LD_WORD   = 2'b10,
        LD_WORD_X = 2'b11
    } ld_size_e;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB result bus, issue notification, and register-file write/busy outputs.
interface wb_stage_if #(
    parameter int DATA_W     = wb_stage_pkg::WB_DATA_W,
    parameter int REG_ADDR_W = wb_stage_pkg::WB_REG_ADDR_W
) ();

    logic                    stall;
    logic                    flush;
    logic                    mem_valid;
    logic                    mem_wreg;
    logic [REG_ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]       mem_alu;
    logic                    mem_is_load;
    logic [1:0]              mem_ld_size;
    logic                    mem_ld_signed;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    issue_en;
    logic [REG_ADDR_W-1:0]   issue_addr;
    logic                    write_en;
    logic [REG_ADDR_W-1:0]   write_addr;
    logic [DATA_W-1:0]       write_data;
    logic [2**REG_ADDR_W-1:0] busy_vec;

    modport master (
        output stall, flush, mem_valid, mem_wreg, mem_waddr, mem_alu,
               mem_is_load, mem_ld_size, mem_ld_signed, mem_rdata,
               issue_en, issue_addr,
        input  write_en, write_addr, write_data, busy_vec
    );

    modport slave (
        input  stall, flush, mem_valid, mem_wreg, mem_waddr, mem_alu,
               mem_is_load, mem_ld_size, mem_ld_signed, mem_rdata,
               issue_en, issue_addr,
        output write_en, write_addr, write_data, busy_vec
    );

endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: extracts a byte/half lane from an aligned memory word and zero/sign-extends it.
module load_align
    import wb_stage_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_lane,
    input  ld_size_e          i_size,
    input  logic              i_signed,
    output logic [DATA_W-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[{i_lane, 3'b000} +: 8];
        w_half = i_rdata[{i_lane[1], 4'b0000} +: 16];
        o_data = i_rdata;
        case (i_size)
            LD_BYTE: o_data = {{(DATA_W-8){i_signed & w_byte[7]}}, w_byte};
            LD_HALF: o_data = {{(DATA_W-16){i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage with per-register pending-write scoreboard.
// Sub-word load extraction is built only when SUBWORD_LOAD_EN is defined.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = WB_DATA_W,
    parameter int REG_ADDR_W = WB_REG_ADDR_W,
    parameter int CNT_W      = WB_CNT_W
) (
    input  logic     clk,
    input  logic     rst,
    wb_stage_if.slave bus
);

    localparam int unsigned NREG = 2**REG_ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                  r_valid;
    logic [REG_ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]     r_data;
    logic [CNT_W-1:0]      r_cnt [NREG];

    logic                  w_cap_valid;
    logic [DATA_W-1:0]     w_load_data;
    logic [DATA_W-1:0]     w_wb_data;
    logic [NREG-1:0]       w_inc;
    logic [NREG-1:0]       w_dec;
    logic [NREG-1:0]       w_busy;

`ifdef SUBWORD_LOAD_EN
    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_rdata  (bus.mem_rdata),
        .i_lane   (bus.mem_alu[1:0]),
        .i_size   (ld_size_e'(bus.mem_ld_size)),
        .i_signed (bus.mem_ld_signed),
        .o_data   (w_load_data)
    );
`else
    assign w_load_data = bus.mem_rdata;
`endif

    assign w_cap_valid = bus.mem_valid && bus.mem_wreg && (bus.mem_waddr != '0);
    assign w_wb_data   = bus.mem_is_load ? w_load_data : bus.mem_alu;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == WB_RST_ACTIVE) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (bus.flush || bus.stall) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_cap_valid;
            r_addr  <= bus.mem_waddr;
            r_data  <= w_wb_data;
        end
    end

    assign bus.write_en   = r_valid;
    assign bus.write_addr = r_addr;
    assign bus.write_data = r_data;

    // Register 0 never increments and never retires, so its counter holds 0
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int unsigned i = 1; i < NREG; i++) begin
            w_inc[i] = bus.issue_en && (bus.issue_addr == REG_ADDR_W'(i));
            w_dec[i] = r_valid && (r_addr == REG_ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == WB_RST_ACTIVE) begin
            for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else if (bus.flush) begin
            for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (w_inc[i] && !w_dec[i]) begin
                    assert (r_cnt[i] != CNT_MAX);
                    if (r_cnt[i] != CNT_MAX) r_cnt[i] <= r_cnt[i] + 1'b1;
                end else if (w_dec[i] && !w_inc[i]) begin
                    assert (r_cnt[i] != '0);
                    if (r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_busy = '0;
        for (int unsigned i = 1; i < NREG; i++) w_busy[i] = (r_cnt[i] != '0);
    end

    assign bus.busy_vec = w_busy;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic vs. an array-based model.
module tb_wb_stage;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int CW   = 2;
    localparam int NREG = 32;
    localparam int CMAX = 3;

    logic clk;
    logic rst;

    wb_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW)) bus ();

    wb_stage #(
        .DATA_W     (DW),
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_cnt [NREG];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] alu,
                                             input logic [1:0] size, input logic sgn);
        logic [31:0] v;
        v = rdata;
`ifdef SUBWORD_LOAD_EN
        if (size == 2'b00) begin
            v = (rdata >> (8 * alu[1:0])) & 32'h0000_00FF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rdata >> (alu[1] ? 16 : 0)) & 32'h0000_FFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < NREG; i++) b[i] = (m_cnt[i] > 0);
        return b;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
    endtask

    // Advance the model by one clock using the inputs currently on the bus
    task automatic model_step();
        if (bus.flush) begin
            for (int i = 0; i < NREG; i++) m_cnt[i] = 0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                bit inc, dec;
                inc = bus.issue_en && (bus.issue_addr == i);
                dec = m_valid && (m_addr == i);
                if (inc && !dec) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                if (dec && !inc) m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
            end
        end
        if (bus.flush || bus.stall) begin
            m_valid = 1'b0;
        end else begin
            m_valid = bus.mem_valid && bus.mem_wreg && (bus.mem_waddr != 0);
            m_addr  = bus.mem_waddr;
            m_data  = bus.mem_is_load ? exp_load(bus.mem_rdata, bus.mem_alu, bus.mem_ld_size, bus.mem_ld_signed)
                                      : bus.mem_alu;
        end
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0;
        bus.mem_valid = 0; bus.mem_wreg = 0; bus.mem_waddr = '0; bus.mem_alu = '0;
        bus.mem_is_load = 0; bus.mem_ld_size = 2'b10; bus.mem_ld_signed = 0; bus.mem_rdata = '0;
        bus.issue_en = 0; bus.issue_addr = '0;
    endtask

    task automatic mem_wr(input logic [4:0] a, input logic [31:0] alu, input bit ld,
                          input logic [1:0] sz, input bit sgn, input logic [31:0] rd);
        bus.mem_valid = 1; bus.mem_wreg = 1; bus.mem_waddr = a; bus.mem_alu = alu;
        bus.mem_is_load = ld; bus.mem_ld_size = sz; bus.mem_ld_signed = sgn; bus.mem_rdata = rd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("wen", bus.write_en, m_valid);
        if (m_valid) begin
            chk("waddr", bus.write_addr, m_addr);
            chk("wdata", bus.write_data, m_data);
        end
        chk("busy", bus.busy_vec, exp_busy());
    endtask

    task automatic issue_tick(input logic [4:0] a);
        idle();
        bus.issue_en = 1; bus.issue_addr = a;
        tick();
    endtask

    initial begin
        logic [31:0] busy_before;
        idle();
        model_reset();
        rst = 1'b0;
        #12;
        chk("rst_wen",   bus.write_en,   1'b0);
        chk("rst_waddr", bus.write_addr, 5'd0);
        chk("rst_wdata", bus.write_data, 32'd0);
        chk("rst_busy",  bus.busy_vec,   32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // ALU path and loads into r5 (three writes, so three issues first)
        for (int k = 0; k < 3; k++) issue_tick(5'd5);
        chk("busy_r5", bus.busy_vec[5], 1'b1);
        idle(); mem_wr(5'd5, 32'h1234_5678, 0, 2'b10, 0, 32'h0);
        tick();
        chk("alu_wen", bus.write_en, 1'b1);
        chk("alu_addr", bus.write_addr, 5'd5);
        chk("alu_data", bus.write_data, 32'h1234_5678);
        idle(); mem_wr(5'd5, 32'h0000_0002, 1, 2'b00, 1, 32'h80FF_7F01);
        tick();
`ifdef SUBWORD_LOAD_EN
        chk("ld_byte_s", bus.write_data, 32'hFFFF_FFFF);
`else
        chk("ld_raw", bus.write_data, 32'h80FF_7F01);
`endif
        idle(); mem_wr(5'd5, 32'h0000_0002, 1, 2'b01, 0, 32'h80FF_7F01);
        tick();
`ifdef SUBWORD_LOAD_EN
        chk("ld_half_u", bus.write_data, 32'h0000_80FF);
`else
        chk("ld_raw2", bus.write_data, 32'h80FF_7F01);
`endif
        idle(); tick();
        chk("r5_clear", bus.busy_vec[5], 1'b0);

        // scoreboard on r3
        issue_tick(5'd3);
        issue_tick(5'd3);
        idle(); mem_wr(5'd3, 32'hA, 0, 2'b10, 0, 0); tick();
        idle(); tick();
        chk("r3_one_left", bus.busy_vec[3], 1'b1);
        idle(); mem_wr(5'd3, 32'hB, 0, 2'b10, 0, 0); tick();
        idle(); tick();
        chk("r3_zero", bus.busy_vec[3], 1'b0);
        issue_tick(5'd3);
        idle(); mem_wr(5'd3, 32'hC, 0, 2'b10, 0, 0); tick();
        idle(); bus.issue_en = 1; bus.issue_addr = 5'd3; tick();
        chk("r3_same_cyc", bus.busy_vec[3], 1'b1);
        idle(); mem_wr(5'd3, 32'hD, 0, 2'b10, 0, 0); tick();
        idle(); tick();
        chk("r3_drained", bus.busy_vec[3], 1'b0);

        // stall and flush
        issue_tick(5'd4);
        idle(); mem_wr(5'd4, 32'h55, 0, 2'b10, 0, 0); bus.stall = 1; tick();
        chk("stall_wen", bus.write_en, 1'b0);
        issue_tick(5'd7);
        issue_tick(5'd7);
        chk("r7_busy", bus.busy_vec[7], 1'b1);
        idle(); bus.flush = 1; bus.stall = 1; bus.issue_en = 1; bus.issue_addr = 5'd7;
        mem_wr(5'd7, 32'h77, 0, 2'b10, 0, 0); tick();
        chk("flush_busy", bus.busy_vec, 32'd0);
        chk("flush_wen", bus.write_en, 1'b0);

        // register 0
        idle(); mem_wr(5'd0, 32'hDEAD_BEEF, 0, 2'b10, 0, 0); tick();
        chk("r0_wen", bus.write_en, 1'b0);
        issue_tick(5'd2);
        busy_before = bus.busy_vec;
        issue_tick(5'd0);
        chk("r0_issue", bus.busy_vec, busy_before);
        idle(); mem_wr(5'd2, 32'h2, 0, 2'b10, 0, 0); tick();
        idle(); tick();

        // randomized traffic on r0..r7, constrained so counters never saturate or underflow
        for (int c = 0; c < 400; c++) begin
            int cn;
            bit dec, inc;
            idle();
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 15) == 0);
            bus.issue_en = $urandom_range(0, 1);
            bus.issue_addr = 5'($urandom_range(0, 7));
            if (bus.issue_en && bus.issue_addr != 0 && !(m_valid && m_addr == bus.issue_addr)
                && m_cnt[bus.issue_addr] >= CMAX) bus.issue_en = 0;
            bus.mem_valid = ($urandom_range(0, 3) != 0);
            bus.mem_wreg = ($urandom_range(0, 4) != 0);
            bus.mem_waddr = 5'($urandom_range(0, 7));
            bus.mem_alu = $urandom();
            bus.mem_rdata = $urandom();
            bus.mem_is_load = $urandom_range(0, 1);
            bus.mem_ld_size = 2'($urandom_range(0, 3));
            bus.mem_ld_signed = $urandom_range(0, 1);
            inc = bus.issue_en && (bus.issue_addr == bus.mem_waddr);
            dec = m_valid && (m_addr == bus.mem_waddr);
            cn = m_cnt[bus.mem_waddr] + (inc ? 1 : 0) - (dec ? 1 : 0);
            if (inc && !dec && m_cnt[bus.mem_waddr] >= CMAX) cn = CMAX;
            if (bus.flush) cn = 0;
            if (bus.mem_valid && bus.mem_wreg && bus.mem_waddr != 0 && !bus.stall && !bus.flush && cn < 1)
                bus.mem_wreg = 0;
            tick();
        end

        // asynchronous reset mid-stream
        idle(); bus.flush = 1; tick();
        issue_tick(5'd9);
        issue_tick(5'd9);
        issue_tick(5'd10);
        idle(); mem_wr(5'd9, 32'h9999, 0, 2'b10, 0, 0); tick();
        chk("pre_rst_wen", bus.write_en, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk("arst_wen",   bus.write_en,   1'b0);
        chk("arst_waddr", bus.write_addr, 5'd0);
        chk("arst_wdata", bus.write_data, 32'd0);
        chk("arst_busy",  bus.busy_vec,   32'd0);
        model_reset();
        idle();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        chk("post_rst_wen", bus.write_en, 1'b0);
        chk("post_rst_busy", bus.busy_vec, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
